// File: rtl/nmea_pkg.sv
// Shared constants, FSM state type and hex helper for the NMEA sentence transmitter.
// The STAR/HEX states exist only when NMEA_CHECKSUM_EN is defined.
package nmea_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DOLLAR,
        S_HEADER,
        S_COMMA,
        S_PAYLOAD,
`ifdef NMEA_CHECKSUM_EN
        S_STAR,
        S_HEX_HI,
        S_HEX_LO,
`endif
        S_CR,
        S_LF
    } state_e;

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/nmea_checksum.sv
// XOR accumulator over the sentence body with uppercase-hex rendering of the result.
// Built only when NMEA_CHECKSUM_EN is defined.
`ifdef NMEA_CHECKSUM_EN
module nmea_checksum
    import nmea_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       update,
    input  logic [7:0] data,
    output logic [7:0] hex_hi,
    output logic [7:0] hex_lo
);

    logic [7:0] sum;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= 8'h00;
        end else if (update) begin
            sum <= sum ^ data;
        end
    end

    assign hex_hi = nibble_to_hex(sum[7:4]);
    assign hex_lo = nibble_to_hex(sum[3:0]);

endmodule
`endif

// File: rtl/nmea_sentence_tx.sv
// Byte-serial NMEA sentence generator: $, header, comma, payload, optional *HH, CR LF.
// NMEA_CHECKSUM_EN defined adds the *HH checksum field.
//
// state   | meaning
// IDLE    | waiting for start
// DOLLAR  | '$' on dout
// HEADER  | header character hdr_cnt on dout
// COMMA   | ',' on dout (INFO_LEN=0 only)
// PAYLOAD | ',' or a payload byte (or bubble) on dout; pay_cnt bytes fetched
// STAR    | '*' on dout
// HEX_HI  | checksum high nibble on dout
// HEX_LO  | checksum low nibble on dout
// CR      | CR on dout
// LF      | LF on dout; done follows its acceptance
module nmea_sentence_tx
    import nmea_pkg::*;
#(
    parameter int                      HEADER_LEN = 5,
    parameter logic [8*HEADER_LEN-1:0] HEADER     = "GPRMC",
    parameter int                      INFO_LEN   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       done
);

    localparam int HW = $clog2(HEADER_LEN + 1);
    localparam int PW = (INFO_LEN > 0) ? $clog2(INFO_LEN + 1) : 1;

`ifdef NMEA_CHECKSUM_EN
    localparam state_e     TAIL_STATE = S_STAR;
    localparam logic [7:0] TAIL_CHAR  = CH_STAR;
`else
    localparam state_e     TAIL_STATE = S_CR;
    localparam logic [7:0] TAIL_CHAR  = CH_CR;
`endif

    state_e          state, state_n;
    logic [HW-1:0]   hdr_cnt, hdr_cnt_n;
    logic [PW-1:0]   pay_cnt, pay_cnt_n;
    logic [7:0]      dout_n;
    logic            dout_valid_n, done_n;
    logic            fire, load_ok;

    function automatic logic [7:0] hdr_char(input logic [HW-1:0] idx);
        return HEADER[8*(HEADER_LEN-1-int'(idx)) +: 8];
    endfunction

`ifdef NMEA_CHECKSUM_EN
    logic       cs_clr, cs_upd;
    logic [7:0] hex_hi, hex_lo;

    nmea_checksum u_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (cs_clr),
        .update (cs_upd),
        .data   (dout),
        .hex_hi (hex_hi),
        .hex_lo (hex_lo)
    );
`endif

    assign fire    = dout_valid && dout_ready;
    assign load_ok = !dout_valid || dout_ready;
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_n      = state;
        hdr_cnt_n    = hdr_cnt;
        pay_cnt_n    = pay_cnt;
        dout_n       = dout;
        dout_valid_n = dout_valid && !dout_ready;
        done_n       = 1'b0;
        din_ready    = 1'b0;
`ifdef NMEA_CHECKSUM_EN
        cs_clr       = 1'b0;
        cs_upd       = 1'b0;
`endif
        case (state)
            S_IDLE: if (start) begin
                state_n      = S_DOLLAR;
                dout_n       = CH_DOLLAR;
                dout_valid_n = 1'b1;
`ifdef NMEA_CHECKSUM_EN
                cs_clr       = 1'b1;
`endif
            end
            S_DOLLAR: if (fire) begin
                state_n      = S_HEADER;
                hdr_cnt_n    = '0;
                dout_n       = hdr_char('0);
                dout_valid_n = 1'b1;
            end
            S_HEADER: if (fire) begin
`ifdef NMEA_CHECKSUM_EN
                cs_upd       = 1'b1;
`endif
                dout_valid_n = 1'b1;
                if (hdr_cnt == HW'(HEADER_LEN - 1)) begin
                    // Comma is shown from PAYLOAD so the first byte is fetched as it leaves.
                    state_n   = (INFO_LEN == 0) ? S_COMMA : S_PAYLOAD;
                    hdr_cnt_n = '0;
                    pay_cnt_n = '0;
                    dout_n    = CH_COMMA;
                end else begin
                    hdr_cnt_n = hdr_cnt + HW'(1);
                    dout_n    = hdr_char(hdr_cnt + HW'(1));
                end
            end
            S_COMMA: if (fire) begin
`ifdef NMEA_CHECKSUM_EN
                cs_upd       = 1'b1;
`endif
                state_n      = TAIL_STATE;
                dout_n       = TAIL_CHAR;
                dout_valid_n = 1'b1;
            end
            S_PAYLOAD: begin
`ifdef NMEA_CHECKSUM_EN
                cs_upd = fire;
`endif
                if (pay_cnt != PW'(INFO_LEN)) begin
                    din_ready = load_ok;
                    if (load_ok && din_valid) begin
                        pay_cnt_n    = pay_cnt + PW'(1);
                        dout_n       = din;
                        dout_valid_n = 1'b1;
                    end
                end else if (fire) begin
                    state_n      = TAIL_STATE;
                    pay_cnt_n    = '0;
                    dout_n       = TAIL_CHAR;
                    dout_valid_n = 1'b1;
                end
            end
`ifdef NMEA_CHECKSUM_EN
            S_STAR: if (fire) begin
                state_n      = S_HEX_HI;
                dout_n       = hex_hi;
                dout_valid_n = 1'b1;
            end
            S_HEX_HI: if (fire) begin
                state_n      = S_HEX_LO;
                dout_n       = hex_lo;
                dout_valid_n = 1'b1;
            end
            S_HEX_LO: if (fire) begin
                state_n      = S_CR;
                dout_n       = CH_CR;
                dout_valid_n = 1'b1;
            end
`endif
            S_CR: if (fire) begin
                state_n      = S_LF;
                dout_n       = CH_LF;
                dout_valid_n = 1'b1;
            end
            S_LF: if (fire) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            hdr_cnt    <= '0;
            pay_cnt    <= '0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            hdr_cnt    <= hdr_cnt_n;
            pay_cnt    <= pay_cnt_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_nmea_sentence_tx.sv
// Directed bench for nmea_sentence_tx: "GPRMC" header, payload "A,1".
// Expected sentence follows NMEA_CHECKSUM_EN.
module tb_nmea_sentence_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;
    int bubbles;

    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [7:0] payload[3];

    nmea_sentence_tx #(
        .HEADER_LEN (5),
        .HEADER     ("GPRMC"),
        .INFO_LEN   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Entered and left just after a rising edge. ready_mode 1 = dout_ready 1,0,0,1 repeating.
    task automatic run_sentence(input int ready_mode, input int gap, input int extra_start,
                                input int rst_at);
        int         lf_c = -1;
        int         pidx = 0;
        int         gapcnt = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_dout = 8'h00;
        got.delete();
        done_seen = 0;
        bubbles   = 0;
        for (int c = 0; c < 200; c++) begin
            start      = (c == 0) || (c == extra_start);
            dout_ready = (ready_mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
            din        = payload[(pidx < 3) ? pidx : 0];
            din_valid  = (pidx < 3) && (gapcnt == 0);
            @(negedge clk);
            if (c == 0) chk("idle_before_start", busy, 1'b0);
            if (c == 1) begin
                chk("first_char_dollar", dout, 8'h24);
                chk("first_char_valid", dout_valid, 1'b1);
                chk("busy_rise", busy, 1'b1);
            end
            if (prev_stall) begin
                chk("stall_dout_hold", dout, prev_dout);
                chk("stall_valid_hold", dout_valid, 1'b1);
            end
            if (dout_valid && !dout_ready) chk("din_ready_while_stalled", din_ready, 1'b0);
            if (rst_at >= 0 && dout_valid && got.size() == rst_at) begin
                rst = 1'b1;
                return;
            end
            if (busy && c > 1 && !dout_valid) bubbles++;
            if (done) done_seen++;
            if (lf_c >= 0 && c == lf_c + 1) begin
                chk("done_after_lf", done, 1'b1);
                chk("busy_low_after_lf", busy, 1'b0);
                chk("valid_low_after_lf", dout_valid, 1'b0);
            end
            if (dout_valid && dout_ready) begin
                got.push_back(dout);
                if (got.size() == exp_q.size()) lf_c = c;
            end
            if (din_valid && din_ready) begin
                pidx++;
                gapcnt = gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            @(posedge clk);
            #1;
            if (lf_c >= 0 && c >= lf_c + 6) break;
        end
        start     = 1'b0;
        din_valid = 1'b0;
        chk("sentence_completed", lf_c >= 0, 1'b1);
        chk("single_done_pulse", done_seen, 1);
    endtask

    task automatic compare_got(input string tag);
        chk({tag, "_length"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        payload = '{8'h41, 8'h2C, 8'h31};
        exp_q = '{8'h24, 8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C, 8'h41, 8'h2C, 8'h31};
`ifdef NMEA_CHECKSUM_EN
        exp_q.push_back(8'h2A);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h42);
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);

        rst        = 1'b1;
        start      = 1'b1;
        din        = 8'h00;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_din_ready", din_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("start_with_rst_ignored", busy, 1'b0);

        run_sentence(0, 0, -1, -1);
        compare_got("basic");
        chk("basic_no_bubbles", bubbles, 0);

        run_sentence(1, 0, -1, -1);
        compare_got("stall");

        run_sentence(0, 3, -1, -1);
        compare_got("gap");
        chk("gap_bubbles_seen", bubbles > 0, 1'b1);

        run_sentence(0, 0, 3, -1);
        compare_got("midstart");

        run_sentence(0, 0, -1, 8);
        start     = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_dout", dout, 8'h00);
        chk("abort_dout_valid", dout_valid, 1'b0);
        chk("abort_din_ready", din_ready, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        rst = 1'b0;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || dout_valid) done_seen++;
            @(posedge clk);
            #1;
        end
        chk("abort_quiet", done_seen, 0);

        run_sentence(0, 0, -1, -1);
        compare_got("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
